// File: rtl/mem_arbiter_pkg.sv
// Shared cache-subsystem definitions: arbiter state encoding and burst geometry.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int unsigned BURST_LEN = 8;
    localparam int unsigned BEAT_W    = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side block-transfer bus between one cache requester and the memory arbiter.
interface mem_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic [2:0]    beat;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          done;

    modport master (
        output req, we, addr, wdata,
        input  gnt, beat, rvalid, rdata, done
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, beat, rvalid, rdata, done
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);
    always_comb begin
        winner = req1 && (!req0 || !last);
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction (m0) and data (m1) cache block bursts onto one main-memory port.
module mem_arbiter #(
    parameter int unsigned AW        = 10,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_LEN = mem_arbiter_pkg::BURST_LEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic [2:0]    m0_beat,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_done,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [2:0]    m1_beat,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);
    import mem_arbiter_pkg::*;

    // Beat counter is 3 bits wide, so BURST_LEN must not exceed 8.
    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

    arb_state_t    state, state_nx;
    logic          win;
    logic          last_gnt;
    logic          we_q;
    logic [AW-4:0] base;
    logic [2:0]    beat;
    logic          rvalid_q;
    logic          rr_winner;
    logic          any_req;
    logic          unused_addr_bits;

    assign any_req          = m0_req || m1_req;
    assign unused_addr_bits = ^{m0_addr[2:0], m1_addr[2:0]};

    rr_arb2 u_rr (
        .req0   (m0_req),
        .req1   (m1_req),
        .last   (last_gnt),
        .winner (rr_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (any_req) state_nx = ST_BURST;
            ST_BURST: if (beat == LAST_BEAT) state_nx = we_q ? ST_DONE : ST_DRAIN;
            ST_DRAIN: state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win      <= 1'b0;
            last_gnt <= 1'b1;
            we_q     <= 1'b0;
            base     <= '0;
            beat     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            // Memory returns data one cycle after the address, so rvalid trails BURST by one.
            rvalid_q <= (state == ST_BURST) && !we_q;
            case (state)
                ST_IDLE: begin
                    beat <= '0;
                    if (any_req) begin
                        win  <= rr_winner;
                        base <= rr_winner ? m1_addr[AW-1:3] : m0_addr[AW-1:3];
                        we_q <= rr_winner ? m1_we : m0_we;
                    end
                end
                ST_BURST: beat <= (beat == LAST_BEAT) ? '0 : beat + 3'd1;
                ST_DONE:  last_gnt <= win;
                default:  ;
            endcase
        end
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_beat   = '0;
        m1_beat   = '0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if (state != ST_IDLE) begin
            m0_gnt = !win;
            m1_gnt = win;
            if (win) m1_beat = beat;
            else     m0_beat = beat;
        end
        if (rvalid_q) begin
            if (win) begin
                m1_rvalid = 1'b1;
                m1_rdata  = mem_dout;
            end else begin
                m0_rvalid = 1'b1;
                m0_rdata  = mem_dout;
            end
        end
        if (state == ST_BURST) begin
            mem_addr = {base, beat};
            mem_we   = we_q;
            mem_din  = win ? m1_wdata : m0_wdata;
        end
        if (state == ST_DONE) begin
            m0_done = !win;
            m1_done = win;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenario bench for mem_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [31:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    mem_arbiter_if #(.AW(10), .DW(32)) m0 ();
    mem_arbiter_if #(.AW(10), .DW(32)) m1 ();

    assign m0.wdata = 32'h200 + 32'(m0.beat);
    assign m1.wdata = 32'h100 + 32'(m1.beat);

    mem_arbiter #(.AW(10), .DW(32), .BURST_LEN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0.req),
        .m0_we     (m0.we),
        .m0_addr   (m0.addr),
        .m0_wdata  (m0.wdata),
        .m0_gnt    (m0.gnt),
        .m0_beat   (m0.beat),
        .m0_rvalid (m0.rvalid),
        .m0_rdata  (m0.rdata),
        .m0_done   (m0.done),
        .m1_req    (m1.req),
        .m1_we     (m1.we),
        .m1_addr   (m1.addr),
        .m1_wdata  (m1.wdata),
        .m1_gnt    (m1.gnt),
        .m1_beat   (m1.beat),
        .m1_rvalid (m1.rvalid),
        .m1_rdata  (m1.rdata),
        .m1_done   (m1.done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        m0.req = 0; m0.we = 0; m0.addr = '0;
        m1.req = 0; m1.we = 0; m1.addr = '0;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({m0.gnt, m0.rvalid, m0.done, m1.gnt, m1.rvalid, m1.done, mem_we} !== 7'b0 ||
            m0.beat !== 3'd0 || m1.beat !== 3'd0 || mem_addr !== 10'd0 || mem_din !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b/%b rv=%b/%b done=%b/%b we=%b addr=%h din=%h required all 0",
                     m0.gnt, m1.gnt, m0.rvalid, m1.rvalid, m0.done, m1.done, mem_we, mem_addr, mem_din);
        end
        rst = 1'b0;
        tick();
        total++;
        if (m0.gnt !== 1'b0 || m1.gnt !== 1'b0 || mem_addr !== 10'd0) begin
            bad++;
            $display("FAIL idle_after_reset: gnt=%b/%b addr=%h required 0/0 000", m0.gnt, m1.gnt, mem_addr);
        end
    endtask

    task automatic test_read_m0();
        m0.addr = 10'h0A5; m0.we = 1'b0; m0.req = 1'b1;
        #1;
        total++;
        if (mem_addr !== 10'h000 || m0.gnt !== 1'b0) begin
            bad++;
            $display("FAIL read_cycle0: addr=%h gnt=%b required 000 0", mem_addr, m0.gnt);
        end
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) m0.req = 1'b0;
            if (c <= 8) begin
                total++;
                if (mem_addr !== 10'(32'h0A0 + c - 1) || m0.beat !== 3'(c - 1)) begin
                    bad++;
                    $display("FAIL read_addr c=%0d: addr=%h beat=%0d required %h %0d",
                             c, mem_addr, m0.beat, 10'(32'h0A0 + c - 1), c - 1);
                end
            end
            total++;
            if (m0.rvalid !== (c >= 2 && c <= 9)) begin
                bad++;
                $display("FAIL read_rvalid c=%0d: got %b required %b", c, m0.rvalid, (c >= 2 && c <= 9));
            end else if (m0.rvalid && m0.rdata !== 32'hA000_00A0 + 32'(c - 2)) begin
                bad++;
                $display("FAIL read_rdata c=%0d: got %h required %h", c, m0.rdata, 32'hA000_00A0 + 32'(c - 2));
            end
            total++;
            if (m0.done !== (c == 10) || m0.gnt !== (c <= 10) || mem_we !== 1'b0 || m1.gnt !== 1'b0) begin
                bad++;
                $display("FAIL read_ctrl c=%0d: done=%b gnt=%b we=%b m1gnt=%b required %b %b 0 0",
                         c, m0.done, m0.gnt, mem_we, m1.gnt, (c == 10), (c <= 10));
            end
        end
    endtask

    task automatic test_write_m1();
        m1.addr = 10'h3F8; m1.we = 1'b1; m1.req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) m1.req = 1'b0;
            if (c <= 8) begin
                total++;
                if (mem_we !== 1'b1 || mem_addr !== 10'(32'h3F8 + c - 1) || mem_din !== 32'h100 + 32'(c - 1)) begin
                    bad++;
                    $display("FAIL write_beat c=%0d: we=%b addr=%h din=%h required 1 %h %h",
                             c, mem_we, mem_addr, mem_din, 10'(32'h3F8 + c - 1), 32'h100 + 32'(c - 1));
                end
            end
            total++;
            if (m1.done !== (c == 9) || m1.gnt !== (c <= 9) || m1.rvalid !== 1'b0 || (c > 8 && mem_we !== 1'b0)) begin
                bad++;
                $display("FAIL write_ctrl c=%0d: done=%b gnt=%b rv=%b we=%b required %b %b 0",
                         c, m1.done, m1.gnt, m1.rvalid, mem_we, (c == 9), (c <= 9));
            end
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (mem[10'h3F8 + k] !== 32'h100 + 32'(k)) begin
                bad++;
                $display("FAIL write_mem k=%0d: got %h required %h", k, mem[10'h3F8 + k], 32'h100 + 32'(k));
            end
        end
    endtask

    task automatic test_tie();
        bit seen;
        apply_reset();
        m0.addr = 10'h010; m0.we = 1'b0; m0.req = 1'b1;
        m1.addr = 10'h200; m1.we = 1'b1; m1.req = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (c == 1 || c == 22) begin
                total++;
                if (m0.gnt !== 1'b1 || m1.gnt !== 1'b0) begin
                    bad++;
                    $display("FAIL tie_m0_first c=%0d: gnt=%b/%b required 1/0", c, m0.gnt, m1.gnt);
                end
            end
            if (c == 10) begin
                total++;
                if (m0.done !== 1'b1) begin
                    bad++;
                    $display("FAIL tie_m0_done: got %b required 1", m0.done);
                end
            end
            if (c == 11) begin
                total++;
                if (m0.gnt !== 1'b0 || m1.gnt !== 1'b0) begin
                    bad++;
                    $display("FAIL tie_idle_gap: gnt=%b/%b required 0/0", m0.gnt, m1.gnt);
                end
            end
            if (c == 12) begin
                total++;
                if (m1.gnt !== 1'b1 || m0.gnt !== 1'b0) begin
                    bad++;
                    $display("FAIL tie_m1_second: gnt=%b/%b required 0/1", m0.gnt, m1.gnt);
                end
            end
            if (c == 20) begin
                total++;
                if (m1.done !== 1'b1) begin
                    bad++;
                    $display("FAIL tie_m1_done: got %b required 1", m1.done);
                end
            end
        end
        m0.req = 1'b0; m1.req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 15 && !seen; n++) begin
            tick();
            if (m0.done) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL tie_third_done: m0_done not seen within 15 cycles, required pulse");
        end
        tick();
    endtask

    task automatic test_drop_req();
        int nrv = 0;
        m0.addr = 10'h045; m0.we = 1'b0; m0.req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 4) begin
                total++;
                if (m0.beat !== 3'd3) begin
                    bad++;
                    $display("FAIL drop_beat3: beat=%0d required 3", m0.beat);
                end
                m0.req = 1'b0;
            end
            if (c == 8) begin
                total++;
                if (mem_addr !== 10'h047) begin
                    bad++;
                    $display("FAIL drop_last_addr: got %h required 047", mem_addr);
                end
            end
            if (m0.rvalid) begin
                nrv++;
                total++;
                if (m0.rdata !== 32'hA000_0040 + 32'(c - 2)) begin
                    bad++;
                    $display("FAIL drop_rdata c=%0d: got %h required %h", c, m0.rdata, 32'hA000_0040 + 32'(c - 2));
                end
            end
            total++;
            if (m0.done !== (c == 10)) begin
                bad++;
                $display("FAIL drop_done c=%0d: got %b required %b", c, m0.done, (c == 10));
            end
        end
        total++;
        if (nrv != 8) begin
            bad++;
            $display("FAIL drop_rvalid_count: got %0d required 8", nrv);
        end
    endtask

    task automatic test_reset_mid_burst();
        int stray = 0;
        m0.addr = 10'h080; m0.we = 1'b0; m0.req = 1'b1;
        for (int c = 1; c <= 5; c++) tick();
        total++;
        if (m0.beat !== 3'd4 || m0.rvalid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_beat4: beat=%0d rv=%b required 4 1", m0.beat, m0.rvalid);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (m0.gnt !== 1'b0 || m0.beat !== 3'd0 || m0.rvalid !== 1'b0 || m0.rdata !== 32'd0 ||
            m0.done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_din !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_async: gnt=%b beat=%0d rv=%b rdata=%h done=%b we=%b addr=%h din=%h required all 0",
                     m0.gnt, m0.beat, m0.rvalid, m0.rdata, m0.done, mem_we, mem_addr, mem_din);
        end
        m0.req = 1'b0;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (m0.done || m0.gnt || m1.gnt) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rstmid_no_done: %0d active cycles after reset, required 0", stray);
        end
        m1.addr = 10'h2A8; m1.we = 1'b1; m1.req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
                m1.req = 1'b0;
                total++;
                if (mem_addr !== 10'h2A8 || mem_we !== 1'b1 || m1.gnt !== 1'b1) begin
                    bad++;
                    $display("FAIL rstmid_m1_start: addr=%h we=%b gnt=%b required 2a8 1 1", mem_addr, mem_we, m1.gnt);
                end
            end
            total++;
            if (m1.done !== (c == 9)) begin
                bad++;
                $display("FAIL rstmid_m1_done c=%0d: got %b required %b", c, m1.done, (c == 9));
            end
        end
        total++;
        if (mem[10'h2A8] !== 32'h100 || mem[10'h2AF] !== 32'h107) begin
            bad++;
            $display("FAIL rstmid_m1_mem: got %h %h required 00000100 00000107", mem[10'h2A8], mem[10'h2AF]);
        end
    endtask

    initial begin
        test_reset();
        test_read_m0();
        test_write_m1();
        test_tie();
        test_drop_req();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 10, main-memory word-address width; DW, 32, data width; BURST_LEN, 8, words per block burst.
REQ-002 Clock and reset SHALL be exactly: one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-003 Ports SHALL be, in order (N = 0 for instruction cache, N = 1 for data cache):
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- mN_req, input, 1: block transfer request.
- mN_we, input, 1: 1 = writeback burst, 0 = fetch burst.
- mN_addr, input, AW: block address; low 3 bits ignored.
- mN_wdata, input, DW: write word for the beat shown on mN_beat.
- mN_gnt, output, 1: requester owns memory.
- mN_beat, output, 3: current write beat index.
- mN_rvalid, output, 1: mN_rdata valid.
- mN_rdata, output, DW: fetched word.
- mN_done, output, 1: one-cycle burst-complete pulse.
- mem_we, output, 1: main-memory write enable.
- mem_addr, output, AW: main-memory address.
- mem_din, output, DW: main-memory write data.
- mem_dout, input, DW: read data, valid one cycle after mem_addr.

Function
REQ-004 The FSM SHALL have states IDLE, BURST, DRAIN and DONE, encoded in 2 bits.
REQ-005 In IDLE with any mN_req high, the arbiter SHALL latch the winner, {mN_addr[AW-1:3],3'b0} and mN_we, clear beat to 0, and enter BURST on the next edge.
REQ-006 When both requests are high in IDLE, the grant SHALL go to the requester not granted last (round-robin); after reset, m0 wins the first tie.
REQ-007 In BURST, outputs SHALL be: mem_addr = base + beat; mem_we = latched we; mem_din = winner's mN_wdata (combinational); beat increments by 1 per cycle.
REQ-008 At beat == BURST_LEN-1, BURST SHALL exit to DRAIN for reads and to DONE for writes; beat arithmetic is 3-bit and never wraps inside a burst.
REQ-009 For reads, mN_rvalid SHALL be high in the cycle after each BURST address cycle (8 consecutive cycles, words in order 0..7), with mN_rdata = mem_dout.
REQ-010 DRAIN SHALL last exactly one cycle, carrying the final rvalid, then go to DONE.
REQ-011 DONE SHALL last one cycle: mN_done = 1 for the winner, last-grant is updated, and the FSM returns to IDLE.
REQ-012 mN_gnt SHALL be high from BURST entry through DONE inclusive; mN_beat SHALL be 0 when the requester is not granted.
REQ-013 mN_req SHALL NOT be sampled outside IDLE; deassertion mid-burst SHALL NOT abort the burst.
REQ-014 A request still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-015 mem_we SHALL be 0 outside write BURST cycles; mem_addr SHALL be 0 in IDLE.
REQ-016 Latency SHALL be as follows, with the req-high IDLE cycle as cycle 0:
- First mem_addr: cycle 1.
- Write done: cycle 9.
- Read done: cycle 10.
- Non-granted outputs: rvalid, done and gnt are 0.

Reset
REQ-017 rst SHALL asynchronously force IDLE, beat 0, last-grant = m1 (so m0 wins ties), and all outputs 0.
REQ-018 rst asserted mid-burst SHALL abort the burst with no mN_done; after release, the FSM restarts from IDLE.

Structure
REQ-019 State encodings and BURST_LEN SHALL live in the shared cache header/package used by the cache and fetch/writeback units.
REQ-020 The round-robin choice SHALL be a sub-module rr_arb2 (inputs req0, req1, last; output winner); the rest stays flat.

Verification
REQ-021 m0 read only, mN_addr = 0x0A5: mem_addr = 0x0A0..0x0A7 in cycles 1-8; m0_rvalid in cycles 2-9; m0_done in cycle 10.
REQ-022 m1 write, addr 0x3F8, wdata = 0x100 + beat: mem_we = 1 for 8 cycles; mem writes 0x100..0x107 to 0x3F8..0x3FF; m1_done in cycle 9.
REQ-023 Both req high after reset: m0 served first, then m1; a tie repeated afterwards alternates m1, m0.
REQ-024 m0_req dropped at beat 3: the burst still completes all 8 beats and m0_done pulses.
REQ-025 rst pulsed during beat 4: all outputs go to 0 immediately, no done, and a new m1 request is served normally.
